// File: rtl/sqrt_share_arbiter.sv
// -----------------------------------------------------------------------------
// sqrt_share_arbiter
//   Lets NUM_REQ client blocks share one iterative square-root unit. Requests
//   are granted in round-robin order. Each grant latches the operand, pulses
//   start, waits for done (a watchdog bounds the wait), then returns the root
//   to the granted client over a valid/ready response.
//
// Ports
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   req_valid_i    per-requester request valid
//   req_data_i     packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o    acceptance strobe, one-hot or zero, only in IDLE
//   rsp_valid_o    response valid for the granted requester (one-hot or zero)
//   rsp_ready_i    per-requester response ready (only the grantee's counts)
//   rsp_root_o     registered root, shared by all requesters
//   rsp_err_o      registered watchdog-abort flag (root forced to 0)
//   sq_start_o     one-cycle start pulse to the sqrt unit
//   sq_operand_o   operand to the sqrt unit, held from accept through RESP
//   sq_done_i      sqrt unit finished, sq_root_i valid this cycle
//   sq_root_i      root from the sqrt unit
//   busy_o         high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sqrt_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 16,
  parameter int ROOT_W     = 8,
  parameter int MAX_CYCLES = 300
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [ROOT_W-1:0]         rsp_root_o,
  output logic                      rsp_err_o,
  output logic                      sq_start_o,
  output logic [DATA_W-1:0]         sq_operand_o,
  input  logic                      sq_done_i,
  input  logic [ROOT_W-1:0]         sq_root_i,
  output logic                      busy_o
);

  localparam int GW = $clog2(NUM_REQ);
  // The counter only has to reach MAX_CYCLES-1.
  localparam int CW = $clog2(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [GW-1:0]       pick;
  logic                pick_vld;
  logic [GW:0]         rr_sum;
  logic [GW-1:0]       rr_idx;
  logic [DATA_W-1:0]   pick_data;
  logic                timeout;

  // Round-robin search: first valid requester at last_grant+1, +2, ...
  // rr_sum is one bit wider so the modulo wrap is a single subtract.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    pick     = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = (GW+1)'(last_grant_q) + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (GW+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[GW-1:0];
      if (!pick_vld && req_valid_i[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Operand of the picked requester.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        pick_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout = (cnt_q == CW'(MAX_CYCLES - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    operand_d    = operand_q;
    root_d       = root_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          operand_d = pick_data;
          grant_d   = pick;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // done has priority over a watchdog expiry in the same cycle
        if (sq_done_i) begin
          root_d  = sq_root_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout) begin
          root_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      operand_q    <= '0;
      root_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      operand_q    <= operand_d;
      root_q       <= root_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs decoded from the state register (ready also from the valid bits).
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state_q == S_IDLE && pick_vld) begin
      req_ready_o[pick] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rsp_valid_o[grant_q] = 1'b1;
    end
  end

  assign sq_start_o   = (state_q == S_LAUNCH);
  assign busy_o       = (state_q != S_IDLE);
  assign sq_operand_o = operand_q;
  assign rsp_root_o   = root_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sqrt_share_arbiter
//   Drives randomized requests into sqrt_share_arbiter, emulates the sqrt unit
//   with a configurable latency, and checks grants, timing, roots and the
//   watchdog against a reference model kept in this file.
// -----------------------------------------------------------------------------
module tb_sqrt_share_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 16;
  localparam int ROOT_W     = 8;
  localparam int MAX_CYCLES = 16;
  localparam int NEVER      = 1000;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid_i = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [NUM_REQ-1:0]        rsp_ready_i = '0;
  logic [ROOT_W-1:0]         rsp_root_o;
  logic                      rsp_err_o;
  logic                      sq_start_o;
  logic [DATA_W-1:0]         sq_operand_o;
  logic                      sq_done_i = 1'b0;
  logic [ROOT_W-1:0]         sq_root_i = '0;
  logic                      busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  // sqrt-unit emulation controls
  int                next_lat   = 1;
  logic              stale_done = 1'b0;
  logic              m_busy     = 1'b0;
  int                m_left     = 0;
  logic [DATA_W-1:0] m_op       = '0;

  // reference round-robin pointer
  int last_g = NUM_REQ - 1;

  always #5 clk = ~clk;

  sqrt_share_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .ROOT_W    (ROOT_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_root_o  (rsp_root_o),
    .rsp_err_o   (rsp_err_o),
    .sq_start_o  (sq_start_o),
    .sq_operand_o(sq_operand_o),
    .sq_done_i   (sq_done_i),
    .sq_root_i   (sq_root_i),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // First valid requester after 'last', wrapping; -1 if none.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Sqrt unit: latches the operand on start, answers after next_lat cycles
  // (counted in WAIT cycles), drives junk on the root bus otherwise.
  always @(negedge clk) begin
    sq_done_i = stale_done;
    sq_root_i = stale_done ? 8'hA5 : ROOT_W'($urandom);
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        if (m_left <= 1) begin
          sq_done_i = 1'b1;
          sq_root_i = ROOT_W'(isqrt(int'(m_op)));
          m_busy    = 1'b0;
        end else begin
          m_left--;
        end
      end
      if (sq_start_o) begin
        m_busy = 1'b1;
        m_left = next_lat;
        m_op   = sq_operand_o;
      end
    end
  end

  task automatic scramble();
    req_valid_i = NUM_REQ'($urandom);
    for (int i = 0; i < NUM_REQ; i++) req_data_i[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  // One full transaction: offer vmask, expect the round-robin grant, run the
  // sqrt unit with latency lat, stall the response for 'hold' cycles.
  task automatic do_txn(input logic [NUM_REQ-1:0] vmask, input int op_force,
                        input int lat, input int hold);
    logic [DATA_W-1:0]  ops [NUM_REQ];
    logic [DATA_W-1:0]  op;
    logic [NUM_REQ-1:0] exp_oh;
    logic [ROOT_W-1:0]  exp_root;
    logic               exp_err;
    int                 g, exp_wait, n;

    @(negedge clk);
    rsp_ready_i = '0;
    for (int i = 0; i < NUM_REQ; i++) ops[i] = DATA_W'($urandom);
    g = rr_pick(vmask, last_g);
    if (g >= 0 && op_force >= 0) ops[g] = DATA_W'(op_force);
    for (int i = 0; i < NUM_REQ; i++) req_data_i[i*DATA_W +: DATA_W] = ops[i];
    req_valid_i = vmask;
    next_lat    = lat;
    #1;
    if (g < 0) begin
      check("idle_ready", req_ready_o, 0);
      check("idle_busy", busy_o, 0);
      return;
    end
    exp_oh    = '0;
    exp_oh[g] = 1'b1;
    op        = ops[g];
    check("accept_ready", req_ready_o, exp_oh);
    check("accept_busy", busy_o, 0);

    // LAUNCH cycle: inputs change freely, operand must already be latched
    @(negedge clk);
    scramble();
    #1;
    check("launch_start", sq_start_o, 1);
    check("launch_operand", sq_operand_o, op);
    check("launch_ready", req_ready_o, 0);
    check("launch_busy", busy_o, 1);

    exp_wait = (lat <= MAX_CYCLES) ? lat + 1 : MAX_CYCLES + 1;
    exp_root = (lat <= MAX_CYCLES) ? ROOT_W'(isqrt(int'(op))) : '0;
    exp_err  = (lat > MAX_CYCLES);
    for (n = 1; n <= MAX_CYCLES + 4; n++) begin
      @(negedge clk);
      scramble();
      #1;
      if (rsp_valid_o != '0) break;
      check("wait_start", sq_start_o, 0);
      check("wait_ready", req_ready_o, 0);
      check("wait_busy", busy_o, 1);
    end
    check("rsp_latency", n, exp_wait);
    if (rsp_valid_o == '0) return;

    check("rsp_valid", rsp_valid_o, exp_oh);
    check("rsp_root", rsp_root_o, exp_root);
    check("rsp_err", rsp_err_o, exp_err);
    check("rsp_operand", sq_operand_o, op);

    // stalled response: other requesters' ready bits must be ignored
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble();
      rsp_ready_i = NUM_REQ'($urandom) & ~exp_oh;
      #1;
      check("hold_valid", rsp_valid_o, exp_oh);
      check("hold_root", rsp_root_o, exp_root);
      check("hold_err", rsp_err_o, exp_err);
      check("hold_ready", req_ready_o, 0);
      check("hold_busy", busy_o, 1);
    end

    // handshake cycle, with live requests that must not be accepted yet
    @(negedge clk);
    scramble();
    req_valid_i = req_valid_i | exp_oh;
    rsp_ready_i = NUM_REQ'($urandom) | exp_oh;
    #1;
    check("hs_valid", rsp_valid_o, exp_oh);
    check("hs_ready", req_ready_o, 0);
    last_g = g;
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_root", rsp_root_o, 0);
    check("rst_err", rsp_err_o, 0);
    check("rst_start", sq_start_o, 0);
    check("rst_operand", sq_operand_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;

    // all four valid from reset: grants 0,1,2,3,0
    repeat (5) do_txn(4'b1111, -1, $urandom_range(1, 6), 0);

    // 144 -> 12 after 12 cycles
    do_txn(4'b0001, 144, 12, 0);

    // requesters 1 and 2 only, starting with last grant 2
    do_txn(4'b0100, -1, 2, 0);
    repeat (4) do_txn(4'b0110, -1, $urandom_range(1, 4), 0);

    // watchdog: never done, done on the last WAIT cycle, done one cycle late
    do_txn(4'b1000, -1, NEVER, 0);
    do_txn(4'b0010, -1, MAX_CYCLES, 0);
    do_txn(4'b0001, -1, MAX_CYCLES + 1, 0);
    do_txn(4'b1111, 65535, 3, 0);

    // stalled response
    do_txn(4'b0100, -1, 5, 5);

    // no requests
    do_txn(4'b0000, -1, 1, 0);

    // randomized traffic
    repeat (40) do_txn(NUM_REQ'($urandom), -1, $urandom_range(1, MAX_CYCLES + 2),
                       $urandom_range(0, 4));

    // reset during WAIT, followed by a stale done
    @(negedge clk);
    rsp_ready_i = '0;
    req_valid_i = 4'b0010;
    next_lat    = NEVER;
    #1;
    check("t6_accept", req_ready_o, 4'b0010);
    @(negedge clk);
    req_valid_i = '0;
    #1;
    check("t6_start", sq_start_o, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("t6_busy", busy_o, 0);
    check("t6_rsp_valid", rsp_valid_o, 0);
    check("t6_root", rsp_root_o, 0);
    check("t6_err", rsp_err_o, 0);
    check("t6_start_off", sq_start_o, 0);
    check("t6_operand", sq_operand_o, 0);
    rst_n      = 1'b1;
    stale_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("stale_busy", busy_o, 0);
      check("stale_rsp_valid", rsp_valid_o, 0);
      check("stale_root", rsp_root_o, 0);
    end
    stale_done = 1'b0;
    last_g     = NUM_REQ - 1;

    // priority restarts at requester 0 after reset
    do_txn(4'b1111, -1, 2, 0);
    do_txn(4'b1111, -1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
